// File: rtl/stage3_alu_pkg.sv
// Shared constants for the stage-3 (execute) ALU: data width and the
// 4-bit function codes carried in the ID/EX register.
package st3_alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_MUL  = 4'b0100;
  localparam logic [3:0] FN_DIV  = 4'b0101;
  localparam logic [3:0] FN_MOVE = 4'b0110;
  localparam logic [3:0] FN_SWAP = 4'b0111;

  // Two's-complement magnitude of a signed word, returned unsigned.
  // 0x8000 maps to 0x8000, which is the correct unsigned magnitude 32768.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    magnitude = v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/stage3_alu_if.sv
// Operand/result bundle between the ID/EX register and the EX/MEM boundary.
// There is no handshake: a new operation is accepted every clock, and its
// results appear on the outputs exactly one rising edge later.
interface stage3_alu_if;
  logic [3:0]  aluFunct;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic [15:0] aluOut1;
  logic [15:0] aluOut2;
  logic        ALU_exception;

  // Upstream side: supplies the function code and operands.
  modport master (
    output aluFunct, reg1, reg2,
    input  aluOut1, aluOut2, ALU_exception
  );

  // ALU side: consumes operands, drives the registered results.
  modport slave (
    input  aluFunct, reg1, reg2,
    output aluOut1, aluOut2, ALU_exception
  );
endinterface

// File: rtl/stage3_alu_div.sv
// Combinational signed 16/16 divider. Quotient truncates toward zero and
// the remainder takes the sign of the dividend (a = q*b + r).
// Division by zero and the single overflowing case (-32768 / -1) are
// flagged and given fixed results.
module st3_alu_div
  import st3_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              div_zero,
  output logic              ovf
);

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic              q_neg;

  // Divide magnitudes unsigned, then restore signs; special cases override.
  always_comb begin
    a_mag    = magnitude(a);
    b_mag    = magnitude(b);
    div_zero = (b == '0);
    ovf      = (a == 16'h8000) && (b == 16'hFFFF);
    // Keep the unsigned divider away from a zero divisor; result is unused then.
    divisor  = div_zero ? 16'h0001 : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;
    q_neg    = a[DATA_W-1] ^ b[DATA_W-1];
    quot     = q_neg ? (~q_mag + 1'b1) : q_mag;
    rem      = a[DATA_W-1] ? (~r_mag + 1'b1) : r_mag;
    if (div_zero) begin
      quot = '0;
      rem  = '0;
    end else if (ovf) begin
      quot = 16'h8000;
      rem  = '0;
    end
  end

endmodule

// File: rtl/stage3_alu.sv
// Stage-3 (execute) ALU. One case on the function code selects among eight
// operations; the two results and the exception flag are registered into
// the EX/MEM boundary every cycle. Results are loaded even when the
// exception fires; squashing the writeback is handled downstream.
module stage3_alu
  import st3_alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  stage3_alu_if.slave  bus
);

  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic signed [31:0]  product;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   div_r;
  logic                div_zero;
  logic                div_ovf;

  logic [DATA_W-1:0]   out1_nx;
  logic [DATA_W-1:0]   out2_nx;
  logic                exc_nx;

  assign a = bus.reg1;
  assign b = bus.reg2;

  assign sum     = a + b;
  assign diff    = a - b;
  assign product = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});

  st3_alu_div u_div (
    .a        (a),
    .b        (b),
    .quot     (div_q),
    .rem      (div_r),
    .div_zero (div_zero),
    .ovf      (div_ovf)
  );

  // Select next results and exception from the current function code.
  always_comb begin
    out1_nx = '0;
    out2_nx = '0;
    exc_nx  = 1'b0;
    case (bus.aluFunct)
      FN_ADD: begin
        out1_nx = sum;
        exc_nx  = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      FN_SUB: begin
        out1_nx = diff;
        exc_nx  = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      FN_AND: out1_nx = a & b;
      FN_OR:  out1_nx = a | b;
      FN_MUL: begin
        out1_nx = product[15:0];
        out2_nx = product[31:16];
      end
      FN_DIV: begin
        out1_nx = div_q;
        out2_nx = div_r;
        exc_nx  = div_zero | div_ovf;
      end
      FN_MOVE: out1_nx = b;
      FN_SWAP: begin
        out1_nx = b;
        out2_nx = a;
      end
      default: begin
        out1_nx = '0;
        out2_nx = '0;
        exc_nx  = 1'b0;
      end
    endcase
  end

  // EX/MEM output registers; reset clears them without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.aluOut1       <= '0;
      bus.aluOut2       <= '0;
      bus.ALU_exception <= 1'b0;
    end else begin
      bus.aluOut1       <= out1_nx;
      bus.aluOut2       <= out2_nx;
      bus.ALU_exception <= exc_nx;
    end
  end

endmodule

// File: tb/tb_stage3_alu.sv
// Bench for stage3_alu: directed vectors from the test plan, then random
// operations checked against an integer-arithmetic reference model.
module tb_stage3_alu;

  logic clk;
  logic rst;

  stage3_alu_if bus ();

  stage3_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {exception, out2, out1}
  logic [32:0] exp_q[$];
  int n_vec;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_model(input logic [3:0] fn,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    int sa, sb, s, q, r;
    longint p;
    logic [15:0] o1, o2;
    logic ex;
    sa = int'($signed(a));
    sb = int'($signed(b));
    o1 = '0; o2 = '0; ex = 1'b0;
    case (fn)
      4'd0: begin s = sa + sb; o1 = s[15:0]; ex = (s > 32767) || (s < -32768); end
      4'd1: begin s = sa - sb; o1 = s[15:0]; ex = (s > 32767) || (s < -32768); end
      4'd2: o1 = a & b;
      4'd3: o1 = a | b;
      4'd4: begin p = longint'(sa) * longint'(sb); o1 = p[15:0]; o2 = p[31:16]; end
      4'd5: begin
        if (sb == 0) begin
          ex = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
          o1 = 16'h8000; ex = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          o1 = q[15:0]; o2 = r[15:0];
        end
      end
      4'd6: o1 = b;
      4'd7: begin o1 = b; o2 = a; end
      default: ;
    endcase
    return {ex, o2, o1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #2;
    bus.aluFunct = fn;
    bus.reg1     = a;
    bus.reg2     = b;
  endtask

  // Directed vector with a hand-derived expected result.
  task automatic apply_dir(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] o1, input logic [15:0] o2, input logic ex);
    drive(fn, a, b);
    exp_q.push_back({ex, o2, o1});
  endtask

  // Random vector checked against the model.
  task automatic apply_rand(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    drive(fn, a, b);
    exp_q.push_back(ref_model(fn, a, b));
  endtask

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got ex=%b out2=%h out1=%h, want ex=%b out2=%h out1=%h",
               name, act[32], act[31:16], act[15:0], req[32], req[31:16], req[15:0]);
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : 16'hFFFF - $urandom_range(0, 4));
      default: return 16'($urandom());
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Each queued entry was pushed before the edge that registers it.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("result", {bus.ALU_exception, bus.aluOut2, bus.aluOut1}, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.aluFunct = 4'hF;
    bus.reg1 = '0;
    bus.reg2 = '0;
    #1;
    check("reset_initial", {bus.ALU_exception, bus.aluOut2, bus.aluOut1}, 33'd0);
    #13;
    rst = 1'b0;

    // Directed vectors (fn, a, b, out1, out2, exc)
    apply_dir(4'h0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 16'h0000, 1'b1);
    apply_dir(4'h0, 16'h0005, 16'h0002, 16'h0007, 16'h0000, 1'b0);
    apply_dir(4'h1, 16'h000F, 16'h000A, 16'h0005, 16'h0000, 1'b0);
    apply_dir(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1);
    apply_dir(4'h1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 1'b1);
    apply_dir(4'h4, 16'h000A, 16'h000A, 16'h0064, 16'h0000, 1'b0);
    apply_dir(4'h4, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0);
    apply_dir(4'h4, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0);
    apply_dir(4'h5, 16'h000A, 16'h0002, 16'h0005, 16'h0000, 1'b0);
    apply_dir(4'h5, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    apply_dir(4'h5, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    apply_dir(4'h5, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1);
    apply_dir(4'h0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    apply_dir(4'h5, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0);
    apply_dir(4'h6, 16'h9999, 16'h1234, 16'h1234, 16'h0000, 1'b0);
    apply_dir(4'h2, 16'h7FFF, 16'h00F0, 16'h00F0, 16'h0000, 1'b0);
    apply_dir(4'h3, 16'h0F00, 16'h000F, 16'h0F0F, 16'h0000, 1'b0);
    apply_dir(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    apply_dir(4'h8, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0);
    apply_dir(4'h7, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 1'b0);

    // Reset mid-stream: ADD 5+2 is presented but reset discards it.
    drive(4'h0, 16'h0005, 16'h0002);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", {bus.ALU_exception, bus.aluOut2, bus.aluOut1}, 33'd0);
    @(posedge clk);
    #1;
    check("reset_hold", {bus.ALU_exception, bus.aluOut2, bus.aluOut1}, 33'd0);
    #3;
    rst = 1'b0;
    #1;
    check("reset_release", {bus.ALU_exception, bus.aluOut2, bus.aluOut1}, 33'd0);
    exp_q.push_back({1'b0, 16'h0000, 16'h0007});

    // Randomized operations against the model.
    for (int i = 0; i < 400; i++) begin
      apply_rand(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end
    bus.aluFunct = 4'hF;

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
